// File: rtl/ahb_master_req_sched_if.sv
// Descriptor, request/grant and status bundle for ahb_master_req_sched.
// master: the scheduler's view. slave: the view of whatever drives descriptors
// and models the slave arbiters.
interface ahb_master_req_sched_if #(
  parameter int unsigned SLAVE_NUM = 4,
  parameter int unsigned SLAVE_BIT = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
);
  logic                 req_valid;
  logic                 req_ready;
  logic [SLAVE_BIT-1:0] req_slave;
  logic [2:0]           req_burst;
  logic [3:0]           req_incr_beats;
  logic [SLAVE_NUM-1:0] hreq;
  logic [2:0]           hburst;
  logic [SLAVE_NUM-1:0] hgrant;
  logic                 hwait;
  logic                 beat_ok;
  logic [3:0]           beat_cnt;
  logic                 xfer_done;
  logic                 xfer_err;
  logic                 busy;

  modport master (
    input  req_valid, req_slave, req_burst, req_incr_beats, hgrant, hwait,
    output req_ready, hreq, hburst, beat_ok, beat_cnt, xfer_done, xfer_err, busy
  );

  modport slave (
    output req_valid, req_slave, req_burst, req_incr_beats, hgrant, hwait,
    input  req_ready, hreq, hburst, beat_ok, beat_cnt, xfer_done, xfer_err, busy
  );
endinterface

// File: rtl/ahb_master_req_sched.sv
// Master-side request scheduler: takes one burst descriptor at a time, holds a
// one-hot request toward the addressed slave arbiter and counts accepted beats
// until the burst completes, then pulses xfer_done (or xfer_err).
// Optional feature: define AHB_REQ_SCHED_TIMEOUT_EN to abandon a request that
// sees no first beat within 2**TIMEOUT_W-1 arbitration cycles.
module ahb_master_req_sched #(
  parameter int unsigned SLAVE_NUM = 4,
  parameter int unsigned SLAVE_BIT = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
  parameter int unsigned TIMEOUT_W = 8
) (
  input logic                    hclk,
  input logic                    hreset,
  ahb_master_req_sched_if.master bus
);

  typedef enum logic [1:0] {StIdle, StArb, StBurst} state_e;

  if (TIMEOUT_W < 1) begin : g_timeout_w_check
    $error("TIMEOUT_W must be at least 1");
  end

  state_e               state_q, state_d;
  logic [SLAVE_NUM-1:0] sel_q, sel_d;          // one-hot target of the active transfer
  logic [2:0]           hburst_q, hburst_d;
  logic [3:0]           last_q, last_d;        // beats_total - 1
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [SLAVE_BIT-1:0] slave_idx;
  logic [SLAVE_NUM-1:0] req_oh;
  logic                 slave_ok;
  logic [3:0]           burst_last;
  logic                 beat;
  logic                 timeout;

  assign slave_idx = bus.req_slave;

  // Decode the incoming descriptor: one-hot target, index range and burst length.
  always_comb begin
    req_oh   = '0;
    slave_ok = (32'(slave_idx) < SLAVE_NUM);
    for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
      req_oh[i] = (32'(slave_idx) == i);
    end
    unique case (bus.req_burst)
      3'd0:       burst_last = 4'd0;                // SINGLE
      3'd1:       burst_last = bus.req_incr_beats;  // INCR
      3'd2, 3'd3: burst_last = 4'd3;                // WRAP4 / INCR4
      3'd4, 3'd5: burst_last = 4'd7;                // WRAP8 / INCR8
      default:    burst_last = 4'd15;               // WRAP16 / INCR16
    endcase
  end

  // Grants are only meaningful for the captured slave while a request is up.
  assign beat = (state_q != StIdle) && (|(bus.hgrant & sel_q)) && !bus.hwait;

`ifdef AHB_REQ_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_q, to_d, to_inc;

  assign to_inc  = to_q + TIMEOUT_W'(1);
  // Counter sits at zero outside ARB, so it is clear on every ARB entry.
  assign to_d    = (state_q == StArb) ? to_inc : '0;
  assign timeout = (state_q == StArb) && !beat && (to_inc == '1);

  // Grant-timeout counter register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic: descriptor capture, beat counting and completion pulses.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    hburst_d   = hburst_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (slave_ok) begin
            sel_d      = req_oh;
            hburst_d   = bus.req_burst;
            last_d     = burst_last;
            beat_cnt_d = '0;
            state_d    = StArb;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StArb: begin
        if (beat) begin
          if (last_q == 4'd0) begin
            beat_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = 4'd1;
            state_d    = StBurst;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StBurst: begin
        if (beat) begin
          // Final beat leaves the count at zero, as the 4-bit wrap does for 16 beats.
          if (beat_cnt_q == last_q) begin
            beat_cnt_d = '0;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-descriptor registers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      hburst_q   <= 3'd0;
      last_q     <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hburst_q   <= hburst_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.hreq      = (state_q != StIdle) ? sel_q : '0;
  assign bus.hburst    = hburst_q;
  assign bus.beat_ok   = beat;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.xfer_done = done_q;
  assign bus.xfer_err  = err_q;

endmodule

// File: tb/tb_ahb_master_req_sched.sv
// Bench for ahb_master_req_sched: directed vector table, multi-cycle corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_ahb_master_req_sched;

  localparam int TO_W     = 4;
  localparam int TO_LIMIT = (1 << TO_W) - 1;
`ifdef AHB_REQ_SCHED_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic hclk = 1'b1;
  logic hreset;

  always #5 hclk = ~hclk;

  ahb_master_req_sched_if #(.SLAVE_NUM(4), .SLAVE_BIT(3)) bus ();

  ahb_master_req_sched #(
    .SLAVE_NUM(4),
    .SLAVE_BIT(3),
    .TIMEOUT_W(TO_W)
  ) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rdy;
    logic [3:0] hreq;
    logic       bok;
    logic [3:0] bcnt;
    logic       done;
    logic       err;
    logic       busy;
    logic [2:0] hb;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] slave;
    logic [2:0] burst;
    logic [3:0] incr;
    logic [3:0] grant;
    logic       hw;
    bit         chk;
    outs_t      exp;
  } vec_t;

  vec_t  tbl[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  outs_t obs;
  bit    model_on = 0;

  // Transaction-level reference state.
  bit         m_active, m_done, m_err;
  int         m_sel, m_total, m_beats, m_wait;
  logic [2:0] m_burst;

  function automatic outs_t sample();
    outs_t o;
    o.rdy  = bus.req_ready;
    o.hreq = bus.hreq;
    o.bok  = bus.beat_ok;
    o.bcnt = bus.beat_cnt;
    o.done = bus.xfer_done;
    o.err  = bus.xfer_err;
    o.busy = bus.busy;
    o.hb   = bus.hburst;
    return o;
  endfunction

  task automatic compare(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b (rdy|hreq|beat_ok|beat_cnt|done|err|busy|hburst)",
               name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int burst_len(input logic [2:0] b, input logic [3:0] incr);
    if (b == 3'd0) return 1;
    if (b == 3'd1) return int'(incr) + 1;
    return 4 << ((int'(b) - 2) / 2);
  endfunction

  function automatic outs_t model_outs();
    outs_t e;
    e.rdy  = !m_active;
    e.hreq = m_active ? 4'(1 << m_sel) : 4'd0;
    e.bok  = m_active && bus.hgrant[m_sel] && !bus.hwait;
    e.bcnt = 4'(m_beats);
    e.done = m_done;
    e.err  = m_err;
    e.busy = m_active;
    e.hb   = m_burst;
    return e;
  endfunction

  function automatic void model_step();
    bit beat;
    beat   = m_active && bus.hgrant[m_sel] && !bus.hwait;
    m_done = 0;
    m_err  = 0;
    if (hreset) begin
      m_active = 0;
      m_beats  = 0;
      m_burst  = 3'd0;
      m_wait   = 0;
      m_sel    = 0;
    end else if (!m_active) begin
      if (bus.req_valid) begin
        if (int'(bus.req_slave) < 4) begin
          m_active = 1;
          m_sel    = int'(bus.req_slave);
          m_total  = burst_len(bus.req_burst, bus.req_incr_beats);
          m_burst  = bus.req_burst;
          m_beats  = 0;
          m_wait   = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (beat) begin
      m_beats++;
      if (m_beats == m_total) begin
        m_active = 0;
        m_done   = 1;
        m_beats  = 0;
      end
    end else if (m_beats == 0) begin
      m_wait++;
      if (TIMEOUT_EN && m_wait == TO_LIMIT) begin
        m_active = 0;
        m_err    = 1;
      end
    end
  endfunction

  // One clock: check at the falling edge, advance the model, return after the rising edge.
  task automatic cycle(input string tag);
    @(negedge hclk);
    obs = sample();
    if (model_on) compare(tag, obs, model_outs());
    model_step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] s, input logic [2:0] b,
                        input logic [3:0] inc, input logic [3:0] g, input logic w);
    bus.req_valid      = v;
    bus.req_slave      = s;
    bus.req_burst      = b;
    bus.req_incr_beats = inc;
    bus.hgrant         = g;
    bus.hwait          = w;
  endtask

  function automatic void add(input logic rst, input logic v, input logic [2:0] s,
                              input logic [2:0] b, input logic [3:0] g, input logic w,
                              input bit chk, input logic rdy, input logic [3:0] hq,
                              input logic bok, input logic [3:0] bc, input logic dn,
                              input logic er, input logic bsy, input logic [2:0] hb);
    vec_t r;
    r.rst = rst; r.valid = v; r.slave = s; r.burst = b; r.incr = 4'd0;
    r.grant = g; r.hw = w; r.chk = chk;
    r.exp = '{rdy: rdy, hreq: hq, bok: bok, bcnt: bc, done: dn, err: er, busy: bsy, hb: hb};
    tbl.push_back(r);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb, first_err;
    bit seen_done, stalled, hreq_drop, seen_busy_end;

    // Reset (2 cycles with req_valid high), SINGLE to slave 2, bad index, INCR4 with strays.
    add(1, 1, 0, 1, 4'b0000, 0, 0, 0, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(1, 1, 0, 1, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 1, 2, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 0, 2, 0, 4'b0000, 0, 1, 0, 4'h4, 0, 4'd0, 0, 0, 1, 3'd0);
    add(0, 0, 2, 0, 4'b0000, 0, 1, 0, 4'h4, 0, 4'd0, 0, 0, 1, 3'd0);
    add(0, 0, 2, 0, 4'b0000, 0, 1, 0, 4'h4, 0, 4'd0, 0, 0, 1, 3'd0);
    add(0, 0, 2, 0, 4'b0100, 0, 1, 0, 4'h4, 1, 4'd0, 0, 0, 1, 3'd0);
    add(0, 0, 0, 0, 4'b0100, 0, 1, 1, 4'h0, 0, 4'd0, 1, 0, 0, 3'd0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 1, 5, 3, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 0, 5, 3, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 1, 0, 3'd0);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 1, 0, 3, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd0);
    add(0, 0, 0, 3, 4'b1000, 0, 1, 0, 4'h1, 0, 4'd0, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b0001, 1, 1, 0, 4'h1, 0, 4'd0, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b0001, 0, 1, 0, 4'h1, 1, 4'd0, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b1001, 0, 1, 0, 4'h1, 1, 4'd1, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b0001, 0, 1, 0, 4'h1, 1, 4'd2, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b0000, 0, 1, 0, 4'h1, 0, 4'd3, 0, 0, 1, 3'd3);
    add(0, 0, 0, 3, 4'b0001, 0, 1, 0, 4'h1, 1, 4'd3, 0, 0, 1, 3'd3);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 1, 0, 0, 3'd3);
    add(0, 0, 0, 0, 4'b0000, 0, 1, 1, 4'h0, 0, 4'd0, 0, 0, 0, 3'd3);

    for (int i = 0; i < tbl.size(); i++) begin
      hreset = tbl[i].rst;
      set_in(tbl[i].valid, tbl[i].slave, tbl[i].burst, tbl[i].incr, tbl[i].grant, tbl[i].hw);
      @(negedge hclk);
      if (tbl[i].chk) compare($sformatf("vec%0d", i), sample(), tbl[i].exp);
      @(posedge hclk);
      #1;
    end

    // Model-checked phase starts from a fresh reset.
    hreset = 1;
    set_in(0, 0, 0, 0, 4'b0000, 0);
    cycle("rst");
    hreset   = 0;
    model_on = 1;

    // INCR8 to slave 1, one wait cycle before beats 3 and 5.
    set_in(1, 1, 5, 0, 4'b0000, 0);
    cycle("incr8_acc");
    set_in(0, 0, 0, 0, 4'b0010, 0);
    nb = 0; stalled = 0; seen_done = 0; hreq_drop = 0;
    for (int k = 0; k < 40 && !seen_done; k++) begin
      bus.hwait = ((nb == 2 || nb == 4) && !stalled);
      if (bus.hwait) stalled = 1;
      cycle("incr8");
      if (obs.bok) begin
        nb++;
        stalled = 0;
      end
      if (obs.done) seen_done = 1;
      else if (obs.hreq != 4'b0010) hreq_drop = 1;
    end
    check_val("incr8_beat_ok_count", nb, 8);
    check_val("incr8_done_seen", int'(seen_done), 1);
    check_val("incr8_hreq_held", int'(hreq_drop), 0);

    // INCR of 16 beats to slave 0, reset asserted on beat 9.
    set_in(1, 0, 1, 4'hF, 4'b0000, 0);
    cycle("incr16_acc");
    set_in(0, 0, 0, 0, 4'b0001, 0);
    nb = 0;
    for (int k = 0; k < 40 && nb < 8; k++) begin
      cycle("incr16");
      if (obs.bok) nb++;
    end
    check_val("incr16_pre_reset_beats", nb, 8);
    hreset = 1;
    cycle("incr16_rst");
    hreset = 0;
    bus.hgrant = 4'b0000;
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      cycle("incr16_post");
      if (k == 0) begin
        check_val("incr16_rst_hreq", int'(obs.hreq), 0);
        check_val("incr16_rst_beat_cnt", int'(obs.bcnt), 0);
      end
      if (obs.done) seen_done = 1;
    end
    check_val("incr16_no_done", int'(seen_done), 0);

    // Ungranted SINGLE to slave 3: timeout if built, otherwise waits for the grant.
    set_in(1, 3, 0, 0, 4'b0000, 0);
    cycle("nogrant_acc");
    bus.req_valid = 0;
    first_err = -1;
    seen_busy_end = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle("nogrant");
      if (obs.err && first_err < 0) begin
        first_err = k;
        seen_busy_end = (obs.busy == 1'b0) && (obs.hreq == 4'b0000);
      end
    end
    if (TIMEOUT_EN) begin
      check_val("timeout_err_cycle", first_err, TO_LIMIT + 1);
      check_val("timeout_released", int'(seen_busy_end), 1);
    end else begin
      check_val("no_timeout_err", first_err, -1);
      check_val("no_timeout_busy", int'(obs.busy), 1);
      bus.hgrant = 4'b1000;
      cycle("late_grant");
      bus.hgrant = 4'b0000;
      cycle("late_done");
      check_val("late_grant_done", int'(obs.done), 1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      hreset = ($urandom_range(0, 199) == 0);
      set_in(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
